// File: rtl/rf_write_arbiter.sv
// Round-robin writeback arbiter for the dual-write-port register file.
// One pending slot per requester; up to two non-conflicting writes issued per cycle.
module rf_write_arbiter #(
   parameter int NREQ = 4,
   parameter int AW   = 4,
   parameter int DW   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   output logic               rf_we,
   output logic [AW-1:0]      rf_waddr1,
   output logic [DW-1:0]      rf_wdata1,
   output logic [AW-1:0]      rf_waddr2,
   output logic [DW-1:0]      rf_wdata2,
   output logic               busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0] pend_valid;
   logic [AW-1:0]   pend_addr [NREQ];
   logic [DW-1:0]   pend_data [NREQ];
   logic [PW-1:0]   rr_ptr;

   logic            found_a;
   logic            found_b;
   logic [PW-1:0]   a_idx;
   logic [PW-1:0]   b_idx;
   logic [PW-1:0]   idx;
   logic [PW:0]     sum;
   logic [PW-1:0]   last_idx;
   logic [PW-1:0]   rr_next;
   logic [NREQ-1:0] gnt;
   logic [NREQ-1:0] accept;

   assign req_ready = ~pend_valid & {NREQ{~flush}};
   assign accept    = req_valid & req_ready;
   assign busy      = (|pend_valid) | rf_we;

   // Scan from rr_ptr; B must target a different register than A.
   always_comb begin
      found_a = 1'b0;
      found_b = 1'b0;
      a_idx   = '0;
      b_idx   = '0;
      idx     = '0;
      sum     = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, rr_ptr} + (PW+1)'(k);
         if (sum >= (PW+1)'(NREQ)) begin
            sum = sum - (PW+1)'(NREQ);
         end
         idx = sum[PW-1:0];
         if (pend_valid[idx]) begin
            if (!found_a) begin
               found_a = 1'b1;
               a_idx   = idx;
            end else if (!found_b &&
                         pend_addr[idx] != pend_addr[a_idx]) begin
               found_b = 1'b1;
               b_idx   = idx;
            end
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (found_a) begin
         gnt[a_idx] = 1'b1;
      end
      if (found_b) begin
         gnt[b_idx] = 1'b1;
      end
      last_idx = found_b ? b_idx : a_idx;
      if (last_idx == PW'(NREQ - 1)) begin
         rr_next = '0;
      end else begin
         rr_next = last_idx + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_valid <= '0;
         rr_ptr     <= '0;
         rf_we      <= 1'b0;
         rf_waddr1  <= '0;
         rf_wdata1  <= '0;
         rf_waddr2  <= '0;
         rf_wdata2  <= '0;
         for (int i = 0; i < NREQ; i++) begin
            pend_addr[i] <= '0;
            pend_data[i] <= '0;
         end
      end else if (flush) begin
         pend_valid <= '0;
         rf_we      <= 1'b0;
      end else begin
         pend_valid <= (pend_valid & ~gnt) | accept;
         for (int i = 0; i < NREQ; i++) begin
            if (accept[i]) begin
               pend_addr[i] <= req_addr[i*AW +: AW];
               pend_data[i] <= req_data[i*DW +: DW];
            end
         end
         rf_we <= found_a;
         // Lone grant goes to both ports: the file writes both when enabled.
         if (found_a) begin
            rr_ptr    <= rr_next;
            rf_waddr1 <= pend_addr[a_idx];
            rf_wdata1 <= pend_data[a_idx];
            if (found_b) begin
               rf_waddr2 <= pend_addr[b_idx];
               rf_wdata2 <= pend_data[b_idx];
            end else begin
               rf_waddr2 <= pend_addr[a_idx];
               rf_wdata2 <= pend_data[a_idx];
            end
         end
      end
   end

endmodule
